// File: rtl/perf_counter_bank_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_pkg;

   typedef enum logic [1:0] {
      PERF_IDLE     = 2'd0,
      PERF_COUNTING = 2'd1,
      PERF_FROZEN   = 2'd2
   } perf_state_t;

   localparam int unsigned PERF_CYCLE_IDX      = 0;
   localparam int unsigned PERF_NUM_EVENTS_DEF = 8;
   localparam int unsigned PERF_CNT_W_DEF      = 32;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Control and read-port bundle of the counter bank; master drives, slave is the bank.
interface perf_counter_bank_if
   import perf_pkg::*;
#(
   parameter int unsigned NUM_EVENTS = PERF_NUM_EVENTS_DEF,
   parameter int unsigned CNT_W      = PERF_CNT_W_DEF,
   parameter int unsigned IDX_W      = $clog2(NUM_EVENTS + 1)
);
   logic                  perf_enable;
   logic                  halt;
   logic [NUM_EVENTS-1:0] ev;
   logic                  clr;
   logic                  snap;
   logic                  rd_req;
   logic [IDX_W-1:0]      rd_idx;
   logic                  rd_valid;
   logic [CNT_W-1:0]      rd_data;
   logic                  rd_ovf;
   logic                  rd_err;
   perf_state_t           state_o;

   modport master (
      output perf_enable, halt, ev, clr, snap, rd_req, rd_idx,
      input  rd_valid, rd_data, rd_ovf, rd_err, state_o
   );

   modport slave (
      input  perf_enable, halt, ev, clr, snap, rd_req, rd_idx,
      output rd_valid, rd_data, rd_ovf, rd_err, state_o
   );
endinterface

// File: rtl/perf_counter_bank_counter.sv
// Single event counter with clear, wrap/saturate overflow and sticky overflow flag.
module perf_counter #(
   parameter int unsigned CNT_W    = 32,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   // Clear wins over a same-cycle increment.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_i) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (inc_i) begin
         if (&cnt_q) begin
            ovf_d = 1'b1;
            cnt_d = SATURATE ? cnt_q : '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;
endmodule

// File: rtl/perf_counter_bank.sv
// Cycle + event counter bank with freeze-on-halt FSM and registered indexed read port.
// Optional shadow snapshot bank enabled by `define PERF_SNAPSHOT_EN.
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int unsigned NUM_EVENTS = PERF_NUM_EVENTS_DEF,
   parameter int unsigned CNT_W      = PERF_CNT_W_DEF,
   parameter bit          SATURATE   = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   perf_counter_bank_if.slave  bus
);
   localparam int unsigned NUM_CH = NUM_EVENTS + 1;

   perf_state_t                  state_q;
   logic                         counting;
   logic [NUM_CH-1:0]            inc;
   logic [NUM_CH-1:0][CNT_W-1:0] live_cnt;
   logic [NUM_CH-1:0]            live_ovf;
   logic [NUM_CH-1:0][CNT_W-1:0] src_cnt;
   logic [NUM_CH-1:0]            src_ovf;

   logic             rd_valid_q;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             rd_ovf_q, rd_ovf_d;
   logic             rd_err_q, rd_err_d;

   // Halt has priority; FROZEN is left only through clr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= PERF_IDLE;
      end else if (bus.halt) begin
         state_q <= PERF_FROZEN;
      end else begin
         case (state_q)
            PERF_IDLE:     if (bus.perf_enable)  state_q <= PERF_COUNTING;
            PERF_COUNTING: if (!bus.perf_enable) state_q <= PERF_IDLE;
            PERF_FROZEN:   if (bus.clr)          state_q <= PERF_IDLE;
            default:                             state_q <= PERF_IDLE;
         endcase
      end
   end

   assign counting = (state_q == PERF_COUNTING);
   assign inc      = {bus.ev, 1'b1} & {NUM_CH{counting}};

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      perf_counter #(
         .CNT_W    (CNT_W),
         .SATURATE (SATURATE)
      ) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc_i (inc[k]),
         .clr_i (bus.clr),
         .cnt_o (live_cnt[k]),
         .ovf_o (live_ovf[k])
      );
   end

`ifdef PERF_SNAPSHOT_EN
   logic [NUM_CH-1:0][CNT_W-1:0] shd_cnt_q;
   logic [NUM_CH-1:0]            shd_ovf_q;

   // Captures pre-update values, so snap+clr keeps the old counts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shd_cnt_q <= '0;
         shd_ovf_q <= '0;
      end else if (bus.snap) begin
         shd_cnt_q <= live_cnt;
         shd_ovf_q <= live_ovf;
      end
   end

   assign src_cnt = shd_cnt_q;
   assign src_ovf = shd_ovf_q;
`else
   assign src_cnt = live_cnt;
   assign src_ovf = live_ovf;
`endif

   always_comb begin
      rd_data_d = '0;
      rd_ovf_d  = 1'b0;
      rd_err_d  = 1'b0;
      if (bus.rd_req) begin
         if (32'(bus.rd_idx) > NUM_EVENTS) begin
            rd_err_d = 1'b1;
         end else begin
            rd_data_d = src_cnt[bus.rd_idx];
            rd_ovf_d  = src_ovf[bus.rd_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_ovf_q   <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_req;
         rd_data_q  <= rd_data_d;
         rd_ovf_q   <= rd_ovf_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_ovf   = rd_ovf_q;
   assign bus.rd_err   = rd_err_q;
   assign bus.state_o  = state_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: one wrapping and one saturating 8-bit instance.
module tb_perf_counter_bank;
   import perf_pkg::*;

   localparam int unsigned NE = 8;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          perf_enable, halt, clr, snap, rd_req;
   logic [NE-1:0] ev;
   logic [3:0]    rd_idx;

   int n_checks = 0;
   int n_pass   = 0;

   logic [CW-1:0] w_data, s_data;
   logic          w_ovf, s_ovf, w_err, s_err, w_valid, s_valid;
   logic [7:0]    exp_snap;

   always #5 clk = ~clk;

   perf_counter_bank_if #(.NUM_EVENTS(NE), .CNT_W(CW)) bus_w ();
   perf_counter_bank_if #(.NUM_EVENTS(NE), .CNT_W(CW)) bus_s ();

   assign bus_w.perf_enable = perf_enable;
   assign bus_w.halt        = halt;
   assign bus_w.ev          = ev;
   assign bus_w.clr         = clr;
   assign bus_w.snap        = snap;
   assign bus_w.rd_req      = rd_req;
   assign bus_w.rd_idx      = rd_idx;
   assign bus_s.perf_enable = perf_enable;
   assign bus_s.halt        = halt;
   assign bus_s.ev          = ev;
   assign bus_s.clr         = clr;
   assign bus_s.snap        = snap;
   assign bus_s.rd_req      = rd_req;
   assign bus_s.rd_idx      = rd_idx;

   perf_counter_bank #(.NUM_EVENTS(NE), .CNT_W(CW), .SATURATE(1'b0)) u_wrap (
      .clk (clk), .rst (rst), .bus (bus_w)
   );
   perf_counter_bank #(.NUM_EVENTS(NE), .CNT_W(CW), .SATURATE(1'b1)) u_sat (
      .clk (clk), .rst (rst), .bus (bus_s)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      perf_enable = 1'b0; halt = 1'b0; clr = 1'b0; snap = 1'b0;
      rd_req = 1'b0; rd_idx = '0; ev = '0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
   endtask

   // Single read: request before an edge, capture the registered beat just after it.
   task automatic rd(input int idx);
      rd_req = 1'b1;
      rd_idx = 4'(idx);
      tick();
      w_data = bus_w.rd_data; w_ovf = bus_w.rd_ovf; w_err = bus_w.rd_err; w_valid = bus_w.rd_valid;
      s_data = bus_s.rd_data; s_ovf = bus_s.rd_ovf; s_err = bus_s.rd_err; s_valid = bus_s.rd_valid;
      rd_req = 1'b0;
   endtask

   initial begin
      do_reset();
      check("rst_state",    64'(bus_w.state_o),  64'd0);
      check("rst_valid",    64'(bus_w.rd_valid), 64'd0);
      check("rst_data",     64'(bus_w.rd_data),  64'd0);
      check("rst_ovf_err",  64'({bus_w.rd_ovf, bus_w.rd_err}), 64'd0);

      // 1: ten counting cycles, four ev[0] pulses
      perf_enable = 1'b1;
      tick();
      check("t1_state_cnt", 64'(bus_w.state_o), 64'd1);
      for (int i = 0; i < 10; i++) begin
         ev[0] = (i < 4);
         if (i == 9) perf_enable = 1'b0;
         tick();
      end
      ev = '0;
      check("t1_state_idle", 64'(bus_w.state_o), 64'd0);
      rd(0);
      check("t1_cyc_valid", 64'(w_valid), 64'd1);
      check("t1_cyc_data",  64'(w_data),  64'd10);
      rd(1);
      check("t1_ev0_data",  64'(w_data),  64'd4);
      check("t1_ev0_valid", 64'(w_valid), 64'd1);
      tick();
      check("t1_valid_drop", 64'(bus_w.rd_valid), 64'd0);

      // 2: overflow at 256 pulses, wrap vs saturate
      do_reset();
      perf_enable = 1'b1;
      tick();
      ev[2] = 1'b1;
      repeat (255) tick();
      ev = '0;
      rd(3);
      check("t2_w_255",     64'(w_data), 64'd255);
      check("t2_w_255_ovf", 64'(w_ovf),  64'd0);
      check("t2_s_255",     64'(s_data), 64'd255);
      ev[2] = 1'b1;
      tick();
      ev = '0;
      rd(3);
      check("t2_w_wrap",    64'(w_data), 64'd0);
      check("t2_w_ovf",     64'(w_ovf),  64'd1);
      check("t2_s_hold",    64'(s_data), 64'd255);
      check("t2_s_ovf",     64'(s_ovf),  64'd1);

      // 3: halt coincident with ev[1], further pulses ignored, clr exits FROZEN
      do_reset();
      perf_enable = 1'b1;
      tick();
      ev[1] = 1'b1;
      halt  = 1'b1;
      tick();
      check("t3_frozen", 64'(bus_w.state_o), 64'd2);
      repeat (5) tick();
      ev = '0;
      rd(2);
      check("t3_ch2", 64'(w_data), 64'd1);
      halt = 1'b0;
      perf_enable = 1'b0;
      tick();
      check("t3_still_frozen", 64'(bus_w.state_o), 64'd2);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("t3_idle", 64'(bus_w.state_o), 64'd0);
      for (int k = 0; k <= int'(NE); k++) begin
         rd(k);
         check($sformatf("t3_clr_ch%0d", k), 64'({w_ovf, w_data}), 64'd0);
      end

      // 4: snap and clr together, then three more events
      do_reset();
      perf_enable = 1'b1;
      tick();
      ev[0] = 1'b1;
      repeat (7) tick();
      ev = '0;
      rd(1);
      check("t4_pre", 64'(w_data), 64'd7);
      snap = 1'b1;
      clr  = 1'b1;
      tick();
      snap = 1'b0;
      clr  = 1'b0;
      ev[0] = 1'b1;
      repeat (3) tick();
      ev = '0;
`ifdef PERF_SNAPSHOT_EN
      exp_snap = 8'd7;
`else
      exp_snap = 8'd3;
`endif
      rd(1);
      check("t4_snap1", 64'(w_data), 64'(exp_snap));
      snap = 1'b1;
      tick();
      snap = 1'b0;
      rd(1);
      check("t4_snap2", 64'(w_data), 64'd3);

      // 5: out-of-range index and back-to-back reads
      rd(NE + 1);
      check("t5_err",      64'(w_err),   64'd1);
      check("t5_err_data", 64'(w_data),  64'd0);
      check("t5_err_vld",  64'(w_valid), 64'd1);
      rd_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rd_idx = 4'(k);
         tick();
         check($sformatf("t5_b2b_vld%0d", k), 64'(bus_w.rd_valid), 64'd1);
         check($sformatf("t5_b2b_err%0d", k), 64'(bus_w.rd_err),   64'd0);
         if (k == 1) check("t5_b2b_ch1", 64'(bus_w.rd_data), 64'd3);
         if (k == 2) check("t5_b2b_ch2", 64'(bus_w.rd_data), 64'd0);
      end
      rd_req = 1'b0;
      tick();
      check("t5_b2b_end", 64'(bus_w.rd_valid), 64'd0);

      // 6: asynchronous reset mid-count
      rd(0);
      check("t6_pre_vld", 64'(w_valid), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("t6_valid", 64'(bus_w.rd_valid), 64'd0);
      check("t6_data",  64'(bus_w.rd_data),  64'd0);
      check("t6_state", 64'(bus_w.state_o),  64'd0);
      check("t6_s_all", 64'({bus_s.rd_valid, bus_s.rd_ovf, bus_s.rd_err, bus_s.rd_data}), 64'd0);
      perf_enable = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rd(0);
      check("t6_cyc_zero", 64'(w_data), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised event-counter bank, the successor to the single-purpose performance monitor attached to the RV32I core. Counts a free-running cycle channel plus `NUM_EVENTS` single-bit event channels (retired, stall, bubble, flush, forward, branch, etc.). Supports wrap or saturate overflow policy, sticky overflow flags, freeze-on-halt tied to program completion, an atomic snapshot, and a one-cycle-latency indexed read port for the testbench or a future CSR path.

## Interface
Parameters:
- `NUM_EVENTS`, default 8: number of event channels; legal range 1–31.
- `CNT_W`, default 32: counter width in bits; legal range 8–64.
- `SATURATE`, default 0: selects the overflow policy; 0 = wrap to 0, 1 = hold at all-ones.
- `IDX_W`, default `$clog2(NUM_EVENTS+1)`: read index width; derived, never overridden.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `perf_enable` input 1: level; allows counting.
- `halt` input 1: level; driven by `program_finished`; freezes the bank.
- `ev` input `NUM_EVENTS`: event pulses; bit k increments channel k+1.
- `clr` input 1: pulse; zeroes the live counters and overflow flags, and exits FROZEN.
- `snap` input 1: pulse; copies all live counters and flags into the shadow bank.
- `rd_req` input 1: read strobe.
- `rd_idx` input `IDX_W`: read index; 0 = cycle channel, k = event channel k.
- `rd_valid` output 1: read data valid.
- `rd_data` output `CNT_W`: read value.
- `rd_ovf` output 1: overflow flag of the channel read.
- `rd_err` output 1: set when `rd_idx` exceeds `NUM_EVENTS`.
- `state_o` output 2: current FSM state.

## Operation
- FSM states: IDLE(0), COUNTING(1), FROZEN(2).
  - IDLE → COUNTING when `perf_enable`=1 and `halt`=0.
  - COUNTING → IDLE when `perf_enable`=0.
  - Any state → FROZEN when `halt`=1. This transition has priority over the IDLE/COUNTING transitions.
  - FROZEN → IDLE only on `clr`.
- Counting rules, applied only in COUNTING:
  - The cycle channel increments by 1 every cycle.
  - Event channel k increments by 1 on each cycle that `ev[k-1]`=1.
- Overflow, when a counter at all-ones is incremented:
  - `SATURATE`=0: the counter wraps to 0.
  - `SATURATE`=1: the counter holds at all-ones.
  - In both cases the channel's sticky `ovf` is set. `ovf` clears only on `clr` or reset.
- `clr` zeroes every live counter and `ovf` flag. `clr` beats a same-cycle increment, so the event is dropped.
- `snap` captures the values present before that edge's update, i.e. pre-clear and pre-increment. `snap` and `clr` in the same cycle therefore give shadow = old values, live = 0.
- Reads:
  - With the shadow bank enabled, reads return shadow values; otherwise they return live values.
  - An out-of-range index returns `rd_data`=0, `rd_ovf`=0, `rd_err`=1.
- `halt` asserted while an event is pulsing in the same cycle: that event is still counted, and counting stops from the next cycle.

## Timing
- Reset values: all counters, shadows and `ovf` flags = 0; state = IDLE; `rd_valid`=0; `rd_data`=0; `rd_ovf`=0; `rd_err`=0; `state_o`=0.
- Count latency: an increment is visible on the live counter one edge after the event.
- Read latency: `rd_valid` rises exactly 1 cycle after `rd_req`.
  - Reads are fully pipelined, one per cycle, with no back-pressure.
  - `rd_valid` is 0 in any cycle not preceded by `rd_req`.
- Read data is registered: a read issued in the same cycle as `snap` or an increment returns the value from before that edge.
- Reset asserted mid-operation clears everything immediately, asynchronously. Reset deassertion is synchronised by the integrator.
- First transition out of IDLE: the cycle channel counts from the first edge where the state is COUNTING.

## Configuration
- Macro: `PERF_SNAPSHOT_EN`.
- Defined: the shadow bank (`NUM_EVENTS+1` × (`CNT_W`+1) bits) is instantiated, `snap` captures as described above, and reads return shadow values.
- Undefined: no shadow registers exist, `snap` is ignored, and reads return live counters and flags.

## Structure
- Shared package `perf_pkg` holds:
  - the `perf_state_t` enum (IDLE/COUNTING/FROZEN);
  - the `PERF_CYCLE_IDX`=0 constant;
  - the default width constants.
- Sub-module `perf_counter`: one `CNT_W` counter with inc, clr, a `SATURATE` parameter and a sticky `ovf`. It is instantiated `NUM_EVENTS+1` times via generate. The FSM, snapshot and read mux stay in the top module.

## Test plan
1. Reset, then `perf_enable`=1 for 10 cycles with `ev[0]` high on 4 of them, then read idx 0 and idx 1 → `rd_data`=10 and 4, `rd_valid` one cycle after each `rd_req`.
2. `CNT_W`=8, `SATURATE`=0, preload 255 via 255 `ev[2]` pulses plus 1 more → channel 3 reads 0 with `rd_ovf`=1. Same test with `SATURATE`=1 → reads 255 with `rd_ovf`=1.
3. `halt`=1 coincident with an `ev[1]` pulse, then 5 further pulses → channel 2 grows by exactly 1 and `state_o`=2. Then `clr` → all counters read 0 and `state_o`=0.
4. `PERF_SNAPSHOT_EN` defined, counter at 7, `snap` and `clr` in the same cycle, then 3 events → read returns 7. A second `snap` then read → returns 3.
5. `rd_idx`=`NUM_EVENTS`+1 → `rd_err`=1, `rd_data`=0. Back-to-back reads of idx 0,1,2 on consecutive cycles → three consecutive valid beats.
6. Assert `rst` low asynchronously mid-count → all outputs 0 before the next clock edge.
